hq_tod_scheduler: RTL and testbench

Per-second sequencer for the HaveQuick II Manchester encoder. On each PPS edge it latches the BCD time-of-day and TFOM, and Hamming(8,4)-encodes the 12 nibbles into the 96-bit encoder message. It then pulses the encoder start and holds the message stable for the full sync-plus-message frame. It sits between the GNSS time/TFOM source and the Manchester encoder, and it detects and counts PPS edges that arrive while a frame is still on the line.

---
 rtl/hq_tod_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_hq_tod_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hq_tod_scheduler.sv
`timescale 1ns/1ps
// hq_tod_scheduler
// Per-second sequencer for the HaveQuick II Manchester encoder. On each accepted
// PPS rising edge it captures the BCD time-of-day and TFOM. It Hamming(8,4)-encodes
// the 12 nibbles into a 96-bit message, pulses the encoder start and then holds the
// message stable for the whole sync + message + guard frame. PPS edges that arrive
// while a frame is still in progress are dropped and counted.
//
// Ports
//   clk_i           system clock
//   rst_ni          asynchronous active-low reset
//   pps_i           PPS, synchronous to clk_i, rising edge significant
//   tx_enable_i     1 = schedule frames; 0 = finish current frame then stop
//   tod_valid_i     time inputs valid; 0 forces the TFOM nibble to 4'h9
//   year_bcd_i      two BCD digits
//   doy_bcd_i       three BCD digits, day of year
//   hour_bcd_i      BCD hours
//   min_bcd_i       BCD minutes
//   sec_bcd_i       BCD seconds
//   tfom_i          time figure of merit
//   enc_start_o     one-cycle start pulse to the encoder
//   enc_time_msg_o  encoded time message, nibble k in [8k+7:8k]
//   busy_o          frame in progress (START or BUSY)
//   frame_cnt_o     frames started, wraps
//   overrun_cnt_o   PPS edges dropped while busy, saturating
module hq_tod_scheduler #(
  parameter int unsigned BIT_CLKS   = 60000,
  parameter int unsigned SYNC_BITS  = 400,
  parameter int unsigned MSG_BITS   = 112,
  parameter int unsigned GUARD_CLKS = 1000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pps_i,
  input  logic        tx_enable_i,
  input  logic        tod_valid_i,
  input  logic [7:0]  year_bcd_i,
  input  logic [11:0] doy_bcd_i,
  input  logic [7:0]  hour_bcd_i,
  input  logic [7:0]  min_bcd_i,
  input  logic [7:0]  sec_bcd_i,
  input  logic [3:0]  tfom_i,
  output logic        enc_start_o,
  output logic [95:0] enc_time_msg_o,
  output logic        busy_o,
  output logic [15:0] frame_cnt_o,
  output logic [7:0]  overrun_cnt_o
);

  localparam int unsigned FRAME_CLKS = (SYNC_BITS + MSG_BITS) * BIT_CLKS + GUARD_CLKS;
  localparam logic [31:0] FRAME_LAST = 32'(FRAME_CLKS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StStart,
    StBusy
  } state_e;

  // Hamming(8,4): byte = {d3,d2,d1,d0,p3,p2,p1,p0}, p3 gives even overall parity.
  function automatic logic [7:0] hamming84(input logic [3:0] d);
    logic p0, p1, p2, p3;
    p0 = d[0] ^ d[1] ^ d[3];
    p1 = d[0] ^ d[2] ^ d[3];
    p2 = d[1] ^ d[2] ^ d[3];
    p3 = d[3] ^ d[2] ^ d[1] ^ d[0] ^ p2 ^ p1 ^ p0;
    return {d, p3, p2, p1, p0};
  endfunction

  state_e state_q, state_d;

  logic        pps_q;
  logic        pps_rise;

  logic        latch_en;
  logic        tod_valid_q;
  logic [7:0]  year_q;
  logic [11:0] doy_q;
  logic [7:0]  hour_q;
  logic [7:0]  min_q;
  logic [7:0]  sec_q;
  logic [3:0]  tfom_q;

  logic [95:0] msg_q, msg_d;
  logic [95:0] msg_enc;
  logic [31:0] timer_q, timer_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  overrun_q, overrun_d;

  assign pps_rise = pps_i & ~pps_q;

  // Edge detector.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pps_q <= 1'b0;
    end else begin
      pps_q <= pps_i;
    end
  end

  // Time-of-day capture, taken in the same cycle the PPS edge is accepted so the
  // message reflects the inputs present at the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tod_valid_q <= 1'b0;
      year_q      <= '0;
      doy_q       <= '0;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      tfom_q      <= '0;
    end else if (latch_en) begin
      tod_valid_q <= tod_valid_i;
      year_q      <= year_bcd_i;
      doy_q       <= doy_bcd_i;
      hour_q      <= hour_bcd_i;
      min_q       <= min_bcd_i;
      sec_q       <= sec_bcd_i;
      tfom_q      <= tfom_i;
    end
  end

  // Message composition from captured values only; first transmitted nibble is
  // nibble 0 in the low byte.
  always_comb begin
    logic [11:0][3:0] nib;
    nib[0]  = year_q[7:4];
    nib[1]  = year_q[3:0];
    nib[2]  = doy_q[11:8];
    nib[3]  = doy_q[7:4];
    nib[4]  = doy_q[3:0];
    nib[5]  = hour_q[7:4];
    nib[6]  = hour_q[3:0];
    nib[7]  = min_q[7:4];
    nib[8]  = min_q[3:0];
    nib[9]  = sec_q[7:4];
    nib[10] = sec_q[3:0];
    nib[11] = tod_valid_q ? tfom_q : 4'h9;
    msg_enc = '0;
    for (int k = 0; k < 12; k++) begin
      msg_enc[8*k +: 8] = hamming84(nib[k]);
    end
  end

  // Sequencer next-state.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    frame_cnt_d = frame_cnt_q;
    msg_d       = msg_q;
    latch_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // With transmit disabled an edge is neither accepted nor an overrun.
        if (pps_rise && tx_enable_i) begin
          latch_en = 1'b1;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        // The only place the message register changes.
        msg_d   = msg_enc;
        state_d = StStart;
      end
      StStart: begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        timer_d     = '0;
        state_d     = StBusy;
      end
      StBusy: begin
        if (timer_q == FRAME_LAST) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Edges during a frame are dropped rather than queued.
  always_comb begin
    overrun_d = overrun_q;
    if (pps_rise && (state_q != StIdle) && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= '0;
      msg_q       <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
      msg_q       <= msg_d;
    end
  end

  assign enc_start_o    = (state_q == StStart);
  assign busy_o         = (state_q == StStart) || (state_q == StBusy);
  assign enc_time_msg_o = msg_q;
  assign frame_cnt_o    = frame_cnt_q;
  assign overrun_cnt_o  = overrun_q;

endmodule

// File: tb/tb_hq_tod_scheduler.sv
`timescale 1ns/1ps
// Bench for hq_tod_scheduler: a cycle-indexed frame model (accept cycle -> start and
// busy window, message snapshot, counters) checked on every falling clock edge, plus
// directed scenarios with hand-computed literal expectations.
module tb_hq_tod_scheduler;

  localparam int unsigned BIT_CLKS   = 4;
  localparam int unsigned SYNC_BITS  = 4;
  localparam int unsigned MSG_BITS   = 4;
  localparam int unsigned GUARD_CLKS = 2;
  localparam longint FRAME = (SYNC_BITS + MSG_BITS) * BIT_CLKS + GUARD_CLKS;  // 34

  // Hand-computed messages for year 25, doy 123, 09:55:00, TFOM 5 / invalid.
  localparam logic [95:0] MSG1 = 96'h5500_0055_559C_0036_2D1B_552D;
  localparam logic [95:0] MSG2 = 96'h9C00_0055_559C_0036_2D1B_552D;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pps;
  logic        tx_enable;
  logic        tod_valid;
  logic [7:0]  year;
  logic [11:0] doy;
  logic [7:0]  hour;
  logic [7:0]  minute;
  logic [7:0]  sec;
  logic [3:0]  tfom;
  logic        enc_start;
  logic [95:0] enc_msg;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [7:0]  overrun_cnt;

  int n_vec = 0;
  int n_err = 0;

  hq_tod_scheduler #(
    .BIT_CLKS  (BIT_CLKS),
    .SYNC_BITS (SYNC_BITS),
    .MSG_BITS  (MSG_BITS),
    .GUARD_CLKS(GUARD_CLKS)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .pps_i         (pps),
    .tx_enable_i   (tx_enable),
    .tod_valid_i   (tod_valid),
    .year_bcd_i    (year),
    .doy_bcd_i     (doy),
    .hour_bcd_i    (hour),
    .min_bcd_i     (minute),
    .sec_bcd_i     (sec),
    .tfom_i        (tfom),
    .enc_start_o   (enc_start),
    .enc_time_msg_o(enc_msg),
    .busy_o        (busy),
    .frame_cnt_o   (frame_cnt),
    .overrun_cnt_o (overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ham(input logic [3:0] d);
    logic p0, p1, p2, p3;
    p0 = d[0] ^ d[1] ^ d[3];
    p1 = d[0] ^ d[2] ^ d[3];
    p2 = d[1] ^ d[2] ^ d[3];
    p3 = (^d) ^ p2 ^ p1 ^ p0;
    return {d, p3, p2, p1, p0};
  endfunction

  function automatic logic [95:0] build(input logic [7:0] y, input logic [11:0] dy,
                                        input logic [7:0] h, input logic [7:0] m,
                                        input logic [7:0] s, input logic [3:0] tf,
                                        input logic v);
    logic [3:0]  n [12];
    logic [95:0] r;
    n[0] = y[7:4];   n[1] = y[3:0];
    n[2] = dy[11:8]; n[3] = dy[7:4];  n[4] = dy[3:0];
    n[5] = h[7:4];   n[6] = h[3:0];
    n[7] = m[7:4];   n[8] = m[3:0];
    n[9] = s[7:4];   n[10] = s[3:0];
    n[11] = v ? tf : 4'h9;
    r = '0;
    for (int k = 0; k < 12; k++) r[8*k +: 8] = ham(n[k]);
    return r;
  endfunction

  // Reference model: a frame accepted at cycle c starts at c+2, is busy through
  // c+2+FRAME and leaves the scheduler free again from c+FRAME+3.
  longint      cyc = 0;
  longint      m_start = -100;
  longint      m_free = 0;
  logic        m_prev = 1'b0;
  logic [95:0] m_pend = '0;
  logic [95:0] m_msg = '0;
  logic [15:0] m_frames = '0;
  logic [7:0]  m_ovr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_start  <= -100;
      m_free   <= 0;
      m_prev   <= 1'b0;
      m_pend   <= '0;
      m_msg    <= '0;
      m_frames <= '0;
      m_ovr    <= '0;
    end else begin
      if (pps && !m_prev) begin
        if (cyc < m_free) begin
          if (m_ovr != 8'hFF) m_ovr <= m_ovr + 8'd1;
        end else if (tx_enable) begin
          m_start <= cyc + 2;
          m_free  <= cyc + FRAME + 3;
          m_pend  <= build(year, doy, hour, minute, sec, tfom, tod_valid);
        end
      end
      if (cyc + 1 == m_start) m_msg <= m_pend;
      if (cyc == m_start) m_frames <= m_frames + 16'd1;
      m_prev <= pps;
    end
  end

  always @(negedge clk) begin
    check("enc_start", 96'(enc_start), 96'(cyc == m_start));
    check("busy", 96'(busy), 96'(cyc >= m_start && cyc <= m_start + FRAME));
    check("frame_cnt", 96'(frame_cnt), 96'(m_frames));
    check("overrun_cnt", 96'(overrun_cnt), 96'(m_ovr));
    check("enc_time_msg", enc_msg, m_msg);
  end

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_tod1();
    tod_valid = 1'b1;
    year = 8'h25; doy = 12'h123; hour = 8'h09; minute = 8'h55; sec = 8'h00; tfom = 4'h5;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    ticks(1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " enc_start"}, 96'(enc_start), 96'd0);
    check({tag, " busy"}, 96'(busy), 96'd0);
    check({tag, " frame_cnt"}, 96'(frame_cnt), 96'd0);
    check({tag, " overrun_cnt"}, 96'(overrun_cnt), 96'd0);
    check({tag, " enc_time_msg"}, enc_msg, 96'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    pps = 1'b0;
    tx_enable = 1'b0;
    set_tod1();
    ticks(2);
    check_all_zero("reset");
    rst_n = 1'b1;
    ticks(2);

    // Pin the model's encoder to known values.
    check("ham 0", 96'(ham(4'h0)), 96'h00);
    check("ham 5", 96'(ham(4'h5)), 96'h55);
    check("ham 9", 96'(ham(4'h9)), 96'h9C);
    check("ham F", 96'(ham(4'hF)), 96'hFF);
    check("model msg1", build(8'h25, 12'h123, 8'h09, 8'h55, 8'h00, 4'h5, 1'b1), MSG1);

    // 1: basic frame, pps rises in cycle N.
    tx_enable = 1'b1;
    pps = 1'b1;
    ticks(1);
    check("t1 no start N+1", 96'(enc_start), 96'd0);
    ticks(1);
    check("t1 start N+2", 96'(enc_start), 96'd1);
    check("t1 busy N+2", 96'(busy), 96'd1);
    ticks(1);
    pps = 1'b0;
    check("t1 frame_cnt", 96'(frame_cnt), 96'd1);
    check("t1 msg", enc_msg, MSG1);
    ticks(33);
    check("t1 busy N+36", 96'(busy), 96'd1);
    ticks(1);
    check("t1 idle N+37", 96'(busy), 96'd0);

    // 2: invalid time forces TFOM nibble to 9.
    tod_valid = 1'b0;
    pps = 1'b1;
    ticks(3);
    pps = 1'b0;
    check("t2 msg", enc_msg, MSG2);
    ticks(34);
    tod_valid = 1'b1;

    // 3: overrun edges at N+10 and N+20, then a normal frame.
    do_reset();
    pps = 1'b1; ticks(3); pps = 1'b0; ticks(7);
    pps = 1'b1; ticks(3); pps = 1'b0; ticks(7);
    pps = 1'b1; ticks(3); pps = 1'b0; ticks(1);
    check("t3 overrun", 96'(overrun_cnt), 96'd2);
    check("t3 frame_cnt one", 96'(frame_cnt), 96'd1);
    ticks(13);
    pps = 1'b1;
    ticks(2);
    check("t3 second start", 96'(enc_start), 96'd1);
    ticks(1);
    pps = 1'b0;
    check("t3 frame_cnt two", 96'(frame_cnt), 96'd2);
    ticks(34);

    // 4: inputs churn during the frame; message stays put.
    set_tod1();
    pps = 1'b1; ticks(3); pps = 1'b0;
    for (int i = 0; i < 33; i++) begin
      year = 8'($urandom); doy = 12'($urandom); hour = 8'($urandom);
      minute = 8'($urandom); sec = 8'($urandom); tfom = 4'($urandom);
      tod_valid = 1'($urandom);
      ticks(1);
    end
    check("t4 msg held", enc_msg, MSG1);
    ticks(1);
    set_tod1();

    // 5: tx_enable drops mid-frame; frame still completes.
    pps = 1'b1; ticks(3); pps = 1'b0;
    ticks(2);
    tx_enable = 1'b0;
    ticks(31);
    check("t5 busy N+36", 96'(busy), 96'd1);
    ticks(1);
    check("t5 idle N+37", 96'(busy), 96'd0);
    ticks(3);
    pps = 1'b1; ticks(3); pps = 1'b0;
    check("t5 no start", 96'(busy), 96'd0);
    check("t5 overrun kept", 96'(overrun_cnt), 96'd2);
    check("t5 frame_cnt", 96'(frame_cnt), 96'd4);
    ticks(3);

    // 6: reset mid-frame clears everything at once.
    tx_enable = 1'b1;
    pps = 1'b1; ticks(3); pps = 1'b0;
    ticks(12);
    rst_n = 1'b0;
    #1;
    check_all_zero("t6 reset");
    ticks(2);
    rst_n = 1'b1;
    ticks(1);
    pps = 1'b1;
    ticks(2);
    check("t6 start", 96'(enc_start), 96'd1);
    ticks(1);
    pps = 1'b0;
    check("t6 frame_cnt", 96'(frame_cnt), 96'd1);
    check("t6 msg", enc_msg, MSG1);
    ticks(35);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
